// File: rtl/seed_dispenser_if.sv
// rtl/seed_dispenser_if.sv - control and status bundle for the seed dispenser
interface seed_dispenser_if;
  logic       enable;
  logic       dispense_req;
  logic       abort;
  logic [7:0] seed_target;
  logic       seed_confirmed;
  logic       solenoid_out;
  logic       busy;
  logic       done;
  logic       fault;
  logic [7:0] seeds_dispensed;
  logic [7:0] retry_count;
  logic [15:0] hole_count;

  modport master (
    output enable, dispense_req, abort, seed_target, seed_confirmed,
    input  solenoid_out, busy, done, fault, seeds_dispensed, retry_count, hole_count
  );

  modport slave (
    input  enable, dispense_req, abort, seed_target, seed_confirmed,
    output solenoid_out, busy, done, fault, seeds_dispensed, retry_count, hole_count
  );
endinterface

// File: rtl/seed_dispenser.sv
// rtl/seed_dispenser.sv - metering solenoid sequencer, one hole per request
// DISPENSE_CONFIRM_EN selects closed-loop seed confirmation; undefined gives open-loop.
module seed_dispenser #(
  parameter int CLOCK_FREQ         = 50000000,
  parameter int PULSE_WIDTH_US     = 200,
  parameter int GAP_US             = 800,
  parameter int CONFIRM_TIMEOUT_US = 20000,
  parameter int MAX_RETRIES        = 3
) (
  input logic             clk,
  input logic             rst_n,
  seed_dispenser_if.slave bus
);
  localparam int CYCLES_PER_US = CLOCK_FREQ / 1000000;
  localparam int PULSE_CYCLES  = CYCLES_PER_US * PULSE_WIDTH_US;
  localparam int GAP_CYCLES    = CYCLES_PER_US * GAP_US;
  localparam logic [31:0] PULSE_LAST = 32'((PULSE_CYCLES > 0) ? PULSE_CYCLES - 1 : 0);
  localparam logic [31:0] GAP_LAST   = 32'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, PULSE, GAP, CONFIRM, DONE, FAULT} state_t;

  state_t      state;
  logic [31:0] timer;
  logic [7:0]  target;
  logic [7:0]  seeds;
  logic [7:0]  retries;
  logic [15:0] holes;
  logic        solenoid;
  logic        busy;
  logic        done;
  logic        fault;
  logic        stop;
  logic [7:0]  seeds_inc;

  assign stop      = bus.abort || !bus.enable;
  assign seeds_inc = seeds + 8'd1;

  assign bus.solenoid_out    = solenoid;
  assign bus.busy            = busy;
  assign bus.done            = done;
  assign bus.fault           = fault;
  assign bus.seeds_dispensed = seeds;
  assign bus.retry_count     = retries;
  assign bus.hole_count      = holes;

`ifdef DISPENSE_CONFIRM_EN
  localparam int TIMEOUT_CYCLES = CYCLES_PER_US * CONFIRM_TIMEOUT_US;
  localparam logic [31:0] TIMEOUT_LAST = 32'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [7:0] seed_retries;
  logic       credited;
  logic       credit_now;

  // Only the first confirmation after a pulse starts counts toward the target.
  assign credit_now = bus.seed_confirmed && !credited && (state == PULSE || state == CONFIRM);
`else
  logic unused_open;
  assign unused_open = bus.seed_confirmed ^ (CONFIRM_TIMEOUT_US > MAX_RETRIES);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      target   <= '0;
      seeds    <= '0;
      retries  <= '0;
      holes    <= '0;
      solenoid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
`ifdef DISPENSE_CONFIRM_EN
      seed_retries <= '0;
      credited     <= 1'b0;
`endif
    end else if (stop) begin
      // Abort beats everything, including a completing confirmation; seeds holds.
      state    <= IDLE;
      timer    <= '0;
      solenoid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FAULT: begin
          if (bus.dispense_req) begin
            target <= bus.seed_target;
            seeds  <= '0;
            fault  <= 1'b0;
            timer  <= '0;
            busy   <= 1'b1;
`ifdef DISPENSE_CONFIRM_EN
            seed_retries <= '0;
            credited     <= 1'b0;
`endif
            if (bus.seed_target == 8'd0) begin
              state <= DONE;
            end else begin
              state    <= PULSE;
              solenoid <= 1'b1;
            end
          end
        end

        PULSE: begin
`ifdef DISPENSE_CONFIRM_EN
          if (credit_now) begin
            credited     <= 1'b1;
            seeds        <= seeds_inc;
            seed_retries <= '0;
          end
`endif
          if (timer == PULSE_LAST) begin
            solenoid <= 1'b0;
            timer    <= '0;
`ifdef DISPENSE_CONFIRM_EN
            if (credit_now) begin
              state <= (seeds_inc == target) ? DONE : GAP;
            end else if (credited) begin
              state <= (seeds == target) ? DONE : GAP;
            end else begin
              state <= CONFIRM;
            end
`else
            seeds <= seeds_inc;
            state <= (seeds_inc == target) ? DONE : GAP;
`endif
          end else begin
            timer <= timer + 32'd1;
          end
        end

`ifdef DISPENSE_CONFIRM_EN
        CONFIRM: begin
          if (credit_now) begin
            credited     <= 1'b1;
            seeds        <= seeds_inc;
            seed_retries <= '0;
            timer        <= '0;
            state        <= (seeds_inc == target) ? DONE : GAP;
          end else if (timer == TIMEOUT_LAST) begin
            timer <= '0;
            if (int'(seed_retries) < MAX_RETRIES) begin
              seed_retries <= seed_retries + 8'd1;
              if (retries != 8'hFF) begin
                retries <= retries + 8'd1;
              end
              state <= GAP;
            end else begin
              state <= FAULT;
              fault <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + 32'd1;
          end
        end
`endif

        GAP: begin
          if (timer == GAP_LAST) begin
            timer    <= '0;
            solenoid <= 1'b1;
            state    <= PULSE;
`ifdef DISPENSE_CONFIRM_EN
            credited <= 1'b0;
`endif
          end else begin
            timer <= timer + 32'd1;
          end
        end

        DONE: begin
          done  <= 1'b1;
          holes <= holes + 16'd1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state    <= IDLE;
          solenoid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seed_dispenser.sv
// tb/tb_seed_dispenser.sv - directed self-checking bench for seed_dispenser
module tb_seed_dispenser;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  int   npulses;
  int   ndone;
  int   wid_err;
  bit   finished;
  bit   saw_bad;

  always #5 clk = ~clk;

  seed_dispenser_if bus ();

  seed_dispenser #(
    .CLOCK_FREQ        (1000000),
    .PULSE_WIDTH_US    (4),
    .GAP_US            (2),
    .CONFIRM_TIMEOUT_US(10),
    .MAX_RETRIES       (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs until done or fault; measures pulse widths; optionally confirms 2 cycles after each pulse.
  task automatic run(input int budget, input bit auto_conf);
    int hi = 0;
    int cd = -1;
    npulses = 0; ndone = 0; wid_err = 0; finished = 0;
    for (int c = 0; c < budget && !finished; c++) begin
      bus.seed_confirmed = (cd == 0);
      if (cd >= 0) cd--;
      tick();
      bus.dispense_req = 1'b0;
      if (bus.solenoid_out) begin
        hi++;
      end else if (hi > 0) begin
        npulses++;
        if (hi != 4) wid_err++;
        hi = 0;
        if (auto_conf) cd = 1;
      end
      if (bus.done) begin ndone++; finished = 1; end
      if (bus.fault) finished = 1;
    end
    bus.seed_confirmed = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] exp_sol;
    logic [11:0] exp_done;
    logic [11:0] exp_busy;
    bus.enable = 1'b1; bus.dispense_req = 1'b0; bus.abort = 1'b0;
    bus.seed_target = 8'd0; bus.seed_confirmed = 1'b0;

    tick(); tick();
    chk("rst_solenoid", bus.solenoid_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_fault", bus.fault, 0);
    chk("rst_seeds", bus.seeds_dispensed, 0);
    chk("rst_retry", bus.retry_count, 0);
    chk("rst_holes", bus.hole_count, 0);
    rst_n = 1'b1;
    tick();

    // Target 0: DONE without any pulse, done two cycles after the request
    bus.dispense_req = 1'b1; bus.seed_target = 8'd0;
    tick();
    bus.dispense_req = 1'b0;
    chk("t0_busy_e0", bus.busy, 1);
    chk("t0_done_e0", bus.done, 0);
    chk("t0_sol_e0", bus.solenoid_out, 0);
    tick();
    chk("t0_done_e1", bus.done, 1);
    chk("t0_busy_e1", bus.busy, 0);
    chk("t0_holes", bus.hole_count, 1);
    chk("t0_sol_e1", bus.solenoid_out, 0);
    tick();
    chk("t0_done_e2", bus.done, 0);

    // Abort in the 2nd cycle of the first pulse
    bus.dispense_req = 1'b1; bus.seed_target = 8'd2;
    tick();
    bus.dispense_req = 1'b0;
    chk("ab_sol_e0", bus.solenoid_out, 1);
    tick();
    chk("ab_sol_e1", bus.solenoid_out, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_sol_after", bus.solenoid_out, 0);
    chk("ab_busy_after", bus.busy, 0);
    saw_bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done || bus.solenoid_out || bus.busy) saw_bad = 1;
    end
    chk("ab_quiet", saw_bad, 0);
    chk("ab_holes", bus.hole_count, 1);
    chk("ab_seeds", bus.seeds_dispensed, 0);

`ifdef DISPENSE_CONFIRM_EN
    // Target 3 with confirmation 2 cycles after each pulse
    bus.dispense_req = 1'b1; bus.seed_target = 8'd3;
    run(200, 1'b1);
    chk("c3_finished", finished, 1);
    chk("c3_pulses", npulses, 3);
    chk("c3_width", wid_err, 0);
    chk("c3_done", ndone, 1);
    chk("c3_seeds", bus.seeds_dispensed, 3);
    chk("c3_holes", bus.hole_count, 2);
    chk("c3_retry", bus.retry_count, 0);

    // Target 1, no confirmations: retries exhausted into FAULT
    bus.dispense_req = 1'b1; bus.seed_target = 8'd1;
    run(120, 1'b0);
    chk("c1_finished", finished, 1);
    chk("c1_pulses", npulses, 3);
    chk("c1_width", wid_err, 0);
    chk("c1_retry", bus.retry_count, 2);
    chk("c1_fault", bus.fault, 1);
    chk("c1_busy", bus.busy, 0);
    chk("c1_done", ndone, 0);
    chk("c1_sol", bus.solenoid_out, 0);
    tick(); tick();
    chk("c1_fault_sticky", bus.fault, 1);

    // Double confirmation within one pulse credits once; request while busy ignored
    bus.dispense_req = 1'b1; bus.seed_target = 8'd2;
    tick();
    bus.dispense_req = 1'b0;
    chk("dc_fault_clr", bus.fault, 0);
    chk("dc_sol_e0", bus.solenoid_out, 1);
    bus.seed_confirmed = 1'b1;
    tick(); tick();
    bus.seed_confirmed = 1'b0;
    bus.dispense_req = 1'b1; bus.seed_target = 8'd9;
    tick();
    bus.dispense_req = 1'b0;
    chk("dc_seeds_e3", bus.seeds_dispensed, 1);
    tick();
    chk("dc_sol_e4", bus.solenoid_out, 0);
    tick(); tick();
    chk("dc_sol_e6", bus.solenoid_out, 1);
    chk("dc_seeds_e6", bus.seeds_dispensed, 1);
    run(80, 1'b1);
    chk("dc_done", ndone, 1);
    chk("dc_seeds", bus.seeds_dispensed, 2);
    chk("dc_holes", bus.hole_count, 3);
`else
    // Open-loop target 2: exact pulse/gap timing, confirm and busy request ignored
    exp_sol  = 12'b111100111100;
    exp_done = 12'b000000000001;
    exp_busy = 12'b111111111110;
    bus.dispense_req = 1'b1; bus.seed_target = 8'd2;
    for (int i = 0; i < 12; i++) begin
      tick();
      bus.dispense_req = 1'b0; bus.seed_confirmed = 1'b0;
      chk($sformatf("ol_sol_c%0d", i), bus.solenoid_out, exp_sol[11-i]);
      chk($sformatf("ol_done_c%0d", i), bus.done, exp_done[11-i]);
      chk($sformatf("ol_busy_c%0d", i), bus.busy, exp_busy[11-i]);
      if (i == 2) begin
        bus.dispense_req = 1'b1; bus.seed_target = 8'd5; bus.seed_confirmed = 1'b1;
      end
    end
    chk("ol_seeds", bus.seeds_dispensed, 2);
    chk("ol_holes", bus.hole_count, 2);
    chk("ol_fault", bus.fault, 0);
    chk("ol_retry", bus.retry_count, 0);

    // enable low during the gap: idle, seeds held, no further pulses
    bus.dispense_req = 1'b1; bus.seed_target = 8'd3;
    tick();
    bus.dispense_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk("en_sol_gap", bus.solenoid_out, 0);
    chk("en_seeds_gap", bus.seeds_dispensed, 1);
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    chk("en_busy", bus.busy, 0);
    saw_bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done || bus.solenoid_out) saw_bad = 1;
    end
    chk("en_quiet", saw_bad, 0);
    chk("en_seeds_hold", bus.seeds_dispensed, 1);
    chk("en_holes", bus.hole_count, 2);

    // Open-loop target 1 via the generic runner
    bus.dispense_req = 1'b1; bus.seed_target = 8'd1;
    run(40, 1'b0);
    chk("o1_pulses", npulses, 1);
    chk("o1_width", wid_err, 0);
    chk("o1_done", ndone, 1);
    chk("o1_holes", bus.hole_count, 3);
`endif

    // Asynchronous reset in mid-pulse
    bus.dispense_req = 1'b1; bus.seed_target = 8'd1;
    tick();
    bus.dispense_req = 1'b0;
    tick();
    chk("ar_sol_before", bus.solenoid_out, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_sol_async", bus.solenoid_out, 0);
    chk("ar_busy_async", bus.busy, 0);
    chk("ar_holes_async", bus.hole_count, 0);
    tick();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
